// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one single-port data RAM between the core load/store
// port and the DMA/debug port. One access per cycle, grant in the request cycle,
// read data registered one cycle later. DMA may lock the port for bursts of at
// most MAX_LOCK grants, after which the core gets one cycle of priority.
// Build option: define DRAM_ARB_RR_EN for round-robin contention resolution;
// otherwise the core always wins contention in the ARB state.
module data_ram_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  input  logic          dma_lock,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
  logic [CW-1:0] lock_cnt_inc;
  logic          lock_full;
  logic          core_wins;

  logic          core_rvalid_reg, dma_rvalid_reg;
  logic [DW-1:0] core_rdata_reg, dma_rdata_reg;

  // lock_cnt is kept at zero outside LOCKED, so the increment also gives the
  // count for the first locked grant taken from ARB.
  assign lock_cnt_inc = lock_cnt_reg + 1'b1;
  assign lock_full    = dma_gnt & dma_lock & (lock_cnt_inc == LOCK_MAX);

`ifdef DRAM_ARB_RR_EN
  logic last_winner_reg;   // 1 = DMA won the last contended cycle
  logic force_core_reg;    // core priority for the cycle after a forced release

  assign core_wins = force_core_reg | last_winner_reg;

  // Round-robin history and post-release core priority
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_winner_reg <= 1'b1;
      force_core_reg  <= 1'b0;
    end else begin
      if (core_req && dma_req && (core_gnt || dma_gnt))
        last_winner_reg <= dma_gnt;
      force_core_reg <= lock_full;
    end
  end
`else
  assign core_wins = 1'b1;
`endif

  // State register and lock counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= ST_ARB;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Next state: stay or enter LOCKED only while DMA keeps a locked grant below the limit
  always_comb begin
    state_next    = ST_ARB;
    lock_cnt_next = '0;
    if (dma_gnt && dma_lock && !lock_full) begin
      state_next    = ST_LOCKED;
      lock_cnt_next = lock_cnt_inc;
    end
  end

  // Grants and RAM port mux
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (RST_N) begin
      if (state_reg == ST_LOCKED) begin
        dma_gnt  = dma_req;
        core_gnt = core_req & ~dma_req;
      end else if (core_req && dma_req) begin
        core_gnt = core_wins;
        dma_gnt  = ~core_wins;
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end
    ram_addr  = dma_gnt ? dma_addr  : core_addr;
    ram_wdata = dma_gnt ? dma_wdata : core_wdata;
    ram_we    = (core_gnt & core_we) | (dma_gnt & dma_we);
  end

  // Registered read data and one-cycle valid pulses
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      core_rvalid_reg <= 1'b0;
      dma_rvalid_reg  <= 1'b0;
      core_rdata_reg  <= '0;
      dma_rdata_reg   <= '0;
    end else begin
      core_rvalid_reg <= core_gnt & ~core_we;
      dma_rvalid_reg  <= dma_gnt & ~dma_we;
      if (core_gnt && !core_we) core_rdata_reg <= ram_rdata;
      if (dma_gnt && !dma_we)   dma_rdata_reg  <= ram_rdata;
    end
  end

  assign core_rvalid = core_rvalid_reg;
  assign dma_rvalid  = dma_rvalid_reg;
  assign core_rdata  = core_rdata_reg;
  assign dma_rdata   = dma_rdata_reg;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed scenarios followed by constrained-random traffic,
// checked every cycle against a transaction-level reference model of the arbiter
// and a shadow copy of the RAM contents.
module tb_data_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_LOCK = 4;

  logic CLK, RST_N;
  logic core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic dma_req, dma_we, dma_gnt, dma_rvalid, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  data_ram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_lock(dma_lock),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM environment: async read, write on posedge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_rdata = mem[ram_addr];
  always @(posedge CLK) if (ram_we) mem[ram_addr] <= ram_wdata;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit in_burst, core_prio, last_dma;
  int burst_len;
  bit m_core_rvalid, m_dma_rvalid;
  logic [DW-1:0] m_core_rdata, m_dma_rdata;
  bit e_core_gnt, e_dma_gnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs_dma_cnt, obs_core_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Who should own the RAM this cycle, from the arbitration rules
  task automatic model_grants();
    e_core_gnt = 1'b0;
    e_dma_gnt  = 1'b0;
    if (RST_N) begin
      if (in_burst) begin
        e_dma_gnt  = dma_req;
        e_core_gnt = core_req && !dma_req;
      end else if (core_req && dma_req) begin
`ifdef DRAM_ARB_RR_EN
        e_dma_gnt = !core_prio && !last_dma;
`else
        e_dma_gnt = 1'b0;
`endif
        e_core_gnt = !e_dma_gnt;
      end else begin
        e_core_gnt = core_req;
        e_dma_gnt  = dma_req;
      end
    end
  endtask

  task automatic model_update();
    bit prio_next;
    if (!RST_N) begin
      in_burst = 0; burst_len = 0; core_prio = 0; last_dma = 1;
      m_core_rvalid = 0; m_dma_rvalid = 0; m_core_rdata = '0; m_dma_rdata = '0;
      return;
    end
    m_core_rvalid = e_core_gnt && !core_we;
    m_dma_rvalid  = e_dma_gnt && !dma_we;
    if (m_core_rvalid) m_core_rdata = ref_mem[core_addr];
    if (m_dma_rvalid)  m_dma_rdata  = ref_mem[dma_addr];
    if (e_core_gnt && core_we) ref_mem[core_addr] = core_wdata;
    if (e_dma_gnt && dma_we)   ref_mem[dma_addr]  = dma_wdata;
    if (core_req && dma_req && (e_core_gnt || e_dma_gnt)) last_dma = e_dma_gnt;
    prio_next = 0;
    if (e_dma_gnt && dma_lock) begin
      burst_len = in_burst ? burst_len + 1 : 1;
      if (burst_len >= MAX_LOCK) begin
        in_burst = 0; burst_len = 0; prio_next = 1;
      end else begin
        in_burst = 1;
      end
    end else begin
      in_burst = 0; burst_len = 0;
    end
    core_prio = prio_next;
  endtask

  // One clock cycle: check at negedge, advance model at posedge, inputs change after
  task automatic tick();
    @(negedge CLK);
    model_grants();
    $display("cyc=%0d rst_n=%b creq=%b dreq=%b lock=%b cgnt=%b dgnt=%b we=%b addr=%02h crv=%b crd=%02h drv=%b drd=%02h",
             cyc, RST_N, core_req, dma_req, dma_lock, core_gnt, dma_gnt, ram_we, ram_addr,
             core_rvalid, core_rdata, dma_rvalid, dma_rdata);
    chk("core_gnt", 32'(core_gnt), 32'(e_core_gnt));
    chk("dma_gnt", 32'(dma_gnt), 32'(e_dma_gnt));
    chk("ram_we", 32'(ram_we), 32'((e_core_gnt && core_we) || (e_dma_gnt && dma_we)));
    chk("ram_addr", 32'(ram_addr), 32'(e_dma_gnt ? dma_addr : core_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_dma_gnt ? dma_wdata : core_wdata));
    chk("core_rvalid", 32'(core_rvalid), 32'(m_core_rvalid));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_dma_rvalid));
    chk("core_rdata", 32'(core_rdata), 32'(m_core_rdata));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_dma_rdata));
    if (dma_gnt) obs_dma_cnt++;
    if (core_gnt) obs_core_cnt++;
    @(posedge CLK);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; dma_req = 0; dma_we = 0; dma_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    idle();
    core_addr = '0; core_wdata = '0; dma_addr = '0; dma_wdata = '0;
    RST_N = 0;
    @(posedge CLK);
    model_update();
    #1;
    tick();  // in reset: grants must be 0
    RST_N = 1;
    chk("reset_core_rdata", 32'(core_rdata), 32'h0);

    // 1: core read of 0x10
    core_req = 1; core_we = 0; core_addr = 8'h10;
    tick();
    idle();
    tick();
    chk("t1_rdata", 32'(core_rdata), 32'hA5);

    // 2: contention, no lock
    obs_dma_cnt = 0;
    core_req = 1; dma_req = 1; core_addr = 8'h01; dma_addr = 8'h02;
    for (int i = 0; i < 4; i++) tick();
`ifdef DRAM_ARB_RR_EN
    chk("t2_dma_share", 32'(obs_dma_cnt), 32'd2);
`else
    chk("t2_dma_share", 32'(obs_dma_cnt), 32'd0);
`endif
    idle();
    tick();

    // 3: DMA write then core read of same address
    dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'h3C;
    tick();
    idle();
    core_req = 1; core_addr = 8'h20;
    tick();
    idle();
    tick();
    chk("t3_raw", 32'(core_rdata), 32'h3C);

    // 4: locked DMA burst with core waiting
    obs_dma_cnt = 0; obs_core_cnt = 0;
    dma_req = 1; dma_lock = 1; dma_addr = 8'h30;
    tick();
    core_req = 1; core_addr = 8'h31;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_burst_len", 32'(obs_dma_cnt), 32'(MAX_LOCK));
    chk("t4_core_waited", 32'(obs_core_cnt), 32'd0);
    tick();
    chk("t4_release", 32'(obs_core_cnt), 32'd1);
    tick();
    idle();
    tick();

    // 5: reset during LOCKED with a read outstanding
    dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 8'h40;
    tick();
    core_req = 1;
    RST_N = 0;
    tick();
    tick();
    chk("t5_rvalid", 32'(dma_rvalid), 32'h0);
    RST_N = 1;
    idle();
    tick();

    // 6: no requests
    for (int i = 0; i < 4; i++) tick();

    // Random traffic: requests hold address/data until granted
    for (int n = 0; n < 400; n++) begin
      if (!core_req && $urandom_range(0, 99) < 60) begin
        core_req = 1; core_we = 1'($urandom);
        core_addr = AW'($urandom_range(0, 15)); core_wdata = DW'($urandom);
      end
      if (!dma_req && $urandom_range(0, 99) < 55) begin
        dma_req = 1; dma_we = 1'($urandom);
        dma_addr = AW'($urandom_range(0, 15)); dma_wdata = DW'($urandom);
      end
      dma_lock = ($urandom_range(0, 99) < 60);
      RST_N = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      tick();
      if (e_core_gnt) core_req = 0;
      if (e_dma_gnt) dma_req = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
